// File: rtl/spi_controller_multi_pkg.sv
// Shared types and helpers for the multi-select SPI write controller.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    BIT_A    = 3'd2,
    BIT_B    = 3'd3,
    GAP      = 3'd4,
    CS_HOLD  = 3'd5
  } state_t;

  localparam int SPI_MODE_HT16D35A = 3;

  function automatic logic spi_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic spi_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_controller_multi_phase_timer.sv
// Loadable down-counter; expire pulses once when a loaded count reaches zero.
module spi_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;
  logic             armed;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      armed <= 1'b0;
    end else if (load) begin
      count <= load_value;
      armed <= 1'b1;
    end else if (armed) begin
      if (count == '0) armed <= 1'b0;
      else             count <= count - 1'b1;
    end
  end

  assign expire = armed && (count == '0);

endmodule

// File: rtl/spi_controller_multi.sv
// Burst SPI write controller, all four SPI modes, inter-byte idle gap.
// Optional read capture on sdi is built when SPI_CONTROLLER_READ_EN is defined.
module spi_controller_multi
  import spi_pkg::*;
#(
  parameter int NUM_SELECTS = 2,
  parameter int CLK_DIV     = 16,
  parameter int GAP_CYCLES  = 100,
  parameter int OUT_BYTES   = 8,
  parameter int SPI_MODE    = SPI_MODE_HT16D35A,
  parameter int CNT_SZ      = $clog2(OUT_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   sck,
  output logic                   sdo,
  output logic [NUM_SELECTS-1:0] cs,
  output logic                   busy,
  output logic                   done,
  input  logic                   activate,
  input  logic [NUM_SELECTS-1:0] in_cs,
  input  logic [7:0]             out_data [OUT_BYTES],
  input  logic [CNT_SZ-1:0]      out_count
`ifdef SPI_CONTROLLER_READ_EN
  ,
  input  logic                   sdi,
  output logic [7:0]             in_data [OUT_BYTES]
`endif
);

  localparam int   HALF   = CLK_DIV / 2;
  localparam int   MAXD   = (HALF > GAP_CYCLES) ? HALF : GAP_CYCLES;
  localparam int   TW     = $clog2(MAXD + 1);
  localparam int   BW     = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam logic CPOL   = spi_cpol(2'(SPI_MODE));
  localparam logic CPHA   = spi_cpha(2'(SPI_MODE));
  localparam logic [TW-1:0] HALF_LD = TW'(HALF - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                   state, state_n;
  logic [NUM_SELECTS-1:0]   cs_mask;
  logic [CNT_SZ-1:0]        count_q;
  logic [BW-1:0]            byte_idx, byte_n;
  logic [2:0]               bit_idx, bit_n;
  logic [7:0]               data_q [OUT_BYTES];
  logic                     sdo_q, done_q, rst_busy;
  logic                     accept, last_byte;
  logic                     timer_load, expire;
  logic [TW-1:0]            timer_value;

  assign accept = (state == IDLE) && !rst_busy && activate && (|in_cs) &&
                  (out_count != '0) && (out_count <= CNT_SZ'(OUT_BYTES));
  assign last_byte = (byte_idx == BW'(count_q - 1'b1));

  spi_phase_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expire     (expire)
  );

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_n     = state;
    byte_n      = byte_idx;
    bit_n       = bit_idx;
    timer_load  = 1'b0;
    timer_value = HALF_LD;
    case (state)
      IDLE: if (accept) begin
        state_n    = CS_SETUP;
        byte_n     = '0;
        bit_n      = 3'd7;
        timer_load = 1'b1;
      end
      CS_SETUP, GAP: if (expire) begin
        state_n    = BIT_A;
        timer_load = 1'b1;
      end
      BIT_A: if (expire) begin
        state_n    = BIT_B;
        timer_load = 1'b1;
      end
      BIT_B: if (expire) begin
        timer_load = 1'b1;
        if (bit_idx != 3'd0) begin
          bit_n   = bit_idx - 1'b1;
          state_n = BIT_A;
        end else if (last_byte) begin
          state_n = CS_HOLD;
        end else begin
          byte_n = byte_idx + 1'b1;
          bit_n  = 3'd7;
          if (GAP_CYCLES == 0) begin
            state_n = BIT_A;
          end else begin
            state_n     = GAP;
            timer_value = GAP_LD;
          end
        end
      end
      CS_HOLD: if (expire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cs_mask  <= '0;
      count_q  <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      sdo_q    <= 1'b0;
      done_q   <= 1'b0;
      rst_busy <= 1'b1;
    end else begin
      state    <= state_n;
      byte_idx <= byte_n;
      bit_idx  <= bit_n;
      rst_busy <= 1'b0;
      done_q   <= (state == CS_HOLD) && expire;
      if (accept) begin
        cs_mask <= in_cs;
        count_q <= out_count;
      end
      if (state_n == BIT_A && state != BIT_A) sdo_q <= data_q[byte_n][bit_n];
      else if (state == CS_HOLD && expire)    sdo_q <= 1'b0;
    end
  end

  // NOTE: payload storage carries no reset; it is always written before being read.
  always_ff @(posedge clk) begin
    if (accept) data_q <= out_data;
  end

`ifdef SPI_CONTROLLER_READ_EN
  logic [6:0] rx_shift;

  // The peripheral drives sdi for the edge that enters BIT_B.
  always_ff @(posedge clk) begin
    if (state == BIT_A && expire) begin
      rx_shift <= {rx_shift[5:0], sdi};
      if (bit_idx == 3'd0) in_data[byte_idx] <= {rx_shift, sdi};
    end
  end
`endif

  always_comb begin
    sck = CPOL;
    if (state == BIT_A)      sck = CPHA ? ~CPOL : CPOL;
    else if (state == BIT_B) sck = CPHA ? CPOL : ~CPOL;
  end

  assign cs   = (state == IDLE) ? '1 : ~cs_mask;
  assign sdo  = sdo_q;
  assign busy = rst_busy || (state != IDLE);
  assign done = done_q;

endmodule
